// File: rtl/dmem_port_arbiter.sv
// DMEM port arbiter: shares one data-memory port between the core LSU and a
// debug/loader port. Core wins by default. A streak counter lets debug in
// after MAX_CORE_BURST consecutive contended core grants. dbg_lock gives
// debug exclusive access. Read data returns to the winner one cycle after
// its grant, at full throughput.
module dmem_port_arbiter #(
    parameter int unsigned MAX_CORE_BURST = 4,  // legal range 1..15
    parameter int unsigned CNT_W          = 4
) (
    input  logic        clk,
    input  logic        rstn,

    // Core load/store unit
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_we,
    input  logic [2:0]  core_ld_sel,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,

    // Debug / loader port
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_we,
    input  logic [2:0]  dbg_ld_sel,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    input  logic        dbg_lock,

    // DMEM port
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_rd,
    output logic [2:0]  mem_ld_sel,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] MaxBurst = CNT_W'(MAX_CORE_BURST);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e           state_q, state_d;
    logic             owner_dbg_q, owner_dbg_d;  // response owner while in StResp
    logic             is_read_q, is_read_d;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic [31:0]      core_rdata_q, dbg_rdata_q;

    logic core_win, dbg_win;
    logic any_gnt;

    // Arbitration: lock first, then starvation guard, then core priority.
    always_comb begin
        core_win = 1'b0;
        dbg_win  = 1'b0;
        if (dbg_lock) begin
            dbg_win = dbg_req;
        end else if (core_req && dbg_req) begin
            if (streak_q == MaxBurst) begin
                dbg_win = 1'b1;
            end else begin
                core_win = 1'b1;
            end
        end else begin
            core_win = core_req;
            dbg_win  = dbg_req;
        end
    end

    // Grants are forced low while reset is asserted, which silences mem_* too.
    assign core_gnt = rstn & core_win;
    assign dbg_gnt  = rstn & dbg_win;
    assign any_gnt  = core_gnt | dbg_gnt;

    // Steer the winner's request onto the DMEM port; idle port drives zeros.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = '0;
        mem_rd     = 1'b0;
        mem_ld_sel = '0;
        if (core_gnt) begin
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_we     = core_we;
            mem_rd     = (core_we == 4'h0);
            mem_ld_sel = core_ld_sel;
        end else if (dbg_gnt) begin
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_we     = dbg_we;
            mem_rd     = (dbg_we == 4'h0);
            mem_ld_sel = dbg_ld_sel;
        end
    end

    // Streak counter: counts contended core grants, saturating at MaxBurst.
    always_comb begin
        streak_d = streak_q;
        if (dbg_lock || !dbg_req || dbg_gnt) begin
            streak_d = '0;
        end else if (core_gnt && (streak_q != MaxBurst)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Response FSM next state: any grant opens (or extends) a response slot.
    always_comb begin
        state_d     = StIdle;
        owner_dbg_d = owner_dbg_q;
        is_read_d   = is_read_q;
        if (any_gnt) begin
            state_d     = StResp;
            owner_dbg_d = dbg_gnt;
            is_read_d   = mem_rd;
        end
    end

    // Response outputs: rdata passes mem_rdata through during the owner's
    // rvalid cycle (writes return 0); otherwise each port holds its last value.
    always_comb begin
        core_rvalid = (state_q == StResp) && !owner_dbg_q;
        dbg_rvalid  = (state_q == StResp) &&  owner_dbg_q;
        core_rdata  = core_rdata_q;
        dbg_rdata   = dbg_rdata_q;
        if (core_rvalid) begin
            core_rdata = is_read_q ? mem_rdata : 32'h0;
        end
        if (dbg_rvalid) begin
            dbg_rdata = is_read_q ? mem_rdata : 32'h0;
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            owner_dbg_q  <= 1'b0;
            is_read_q    <= 1'b0;
            streak_q     <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_dbg_q  <= owner_dbg_d;
            is_read_q    <= is_read_d;
            streak_q     <= streak_d;
            core_rdata_q <= core_rdata;
            dbg_rdata_q  <= dbg_rdata;
        end
    end

    // Grants are mutually exclusive and the core never wins under lock.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn)
        !(core_gnt && dbg_gnt));
    a_lock_excl : assert property (@(posedge clk) disable iff (!rstn)
        dbg_lock |-> !core_gnt);
    a_streak_sat : assert property (@(posedge clk) disable iff (!rstn)
        streak_q <= MaxBurst);

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single DMEM port between two requesters: the core load/store unit (core_*) and a debug/loader port (dbg_*).
- Sits between the LSU/debug logic and DMEM.
- Each cycle it arbitrates, drives the winner's request onto DMEM, and returns read data to the winner one cycle later.
- Core has default priority; a starvation counter guarantees debug progress, and a lock input gives debug exclusive access.

Parameters:
- MAX_CORE_BURST, 4: consecutive core grants allowed while dbg_req is pending before debug wins one slot (legal range 1..15).
- CNT_W, 4: width of the streak counter.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous reset, active-low
- core_req  in  1  core request; addr/wdata/we/ld_sel held stable until core_gnt
- core_addr  in  32  byte address
- core_wdata  in  32  write data
- core_we  in  4  byte write enables; 0 = read
- core_ld_sel  in  3  load select, passed to DMEM load_select
- core_gnt  out  1  request accepted this cycle
- core_rvalid  out  1  response for the core request granted last cycle
- core_rdata  out  32  read data; 0 for writes
- dbg_req, dbg_addr, dbg_wdata, dbg_we, dbg_ld_sel, dbg_gnt, dbg_rvalid, dbg_rdata: same as core_*, for the debug port
- dbg_lock  in  1  debug exclusive mode; core never granted while high
- mem_addr  out  32  to DMEM addr_in
- mem_wdata  out  32  to DMEM data_in
- mem_we  out  4  to DMEM we
- mem_rd  out  1  to DMEM rd
- mem_ld_sel  out  3  to DMEM load_select
- mem_rdata  in  32  from DMEM data_out, valid one cycle after address

Behaviour:
Reset (rstn low, asynchronous):
- Register outputs clear: *_rvalid=0, *_rdata=0.
- Streak counter=0; owner register=NONE.
- Combinational outputs are forced to 0 while rstn is low: *_gnt=0, mem_we=0, mem_rd=0, mem_addr=0, mem_wdata=0, mem_ld_sel=0.

Arbitration (combinational, every cycle):
- dbg_lock=1: grant dbg if dbg_req, else nobody.
- Else if core_req and dbg_req: grant dbg if streak==MAX_CORE_BURST, else grant core.
- Else grant whichever requester is active.
- Exactly one of core_gnt/dbg_gnt is high, or neither.

DMEM drive (combinational):
- The winner's addr, wdata and ld_sel go to mem_*.
- mem_we = winner we.
- mem_rd = 1 iff winner we==0.
- No grant: mem_we=0, mem_rd=0, mem_addr=0, mem_wdata=0.

Streak counter:
- Core granted while dbg_req=1: increment, saturating at MAX_CORE_BURST.
- dbg granted, dbg_req=0, or dbg_lock=1: clear to 0.

Response pipeline (1-cycle latency, full throughput):
- On a grant, register owner (CORE/DBG) and is_read.
- Next cycle, owner_rvalid=1 for exactly one cycle.
- owner_rdata = mem_rdata if is_read, else 0. Non-owner rdata holds its previous value.
- A new grant can occur in the same cycle as the rvalid for the previous one (back-to-back).

Boundary conditions:
- dbg_lock asserted while a core response is in flight: that response still completes.
- Reset mid-access: the in-flight rvalid is dropped.
- A requester that deasserts req before its grant is simply not granted; no error.
- Address map is not checked; DMEM handles decoding (0x0010_00xx MMIO, 0x8000_0000 RAM).

FSM: two states.
- IDLE: no owner.
- RESP: owner valid.
- IDLE->RESP on any grant; RESP->RESP on a new grant; RESP->IDLE with no grant.

Test Plan:
1. Core only: core_we=4'hF write 0xDEADBEEF to 0x80000010, then read with we=0. Expect core_gnt each cycle; read rvalid one cycle after grant with rdata=0xDEADBEEF; write rvalid has rdata=0.
2. Contention: core_req and dbg_req held high for 10 cycles, MAX_CORE_BURST=4. Expect grant sequence C,C,C,C,D,C,C,C,C,D; each rvalid goes to the correct port one cycle later.
3. Lock: dbg_lock=1 with both requesting. Expect core_gnt=0 throughout; dbg writes 0x12345678 to 0x00100014 (LED) and reads back 0x12345678.
4. Back-to-back: dbg reads 0x80000000, 0x80000004, 0x80000008 on consecutive cycles. Expect three consecutive dbg_rvalid with the matching DMEM data and no bubbles.
5. Reset mid-op: rstn low in the cycle after a core read grant. Expect core_rvalid=0, mem_rd=0 immediately (asynchronous); after release, the first grant goes to core.
6. Idle: no requests. Expect mem_we=0, mem_rd=0, mem_addr=0, and no rvalid.
